spi_write_master: RTL and testbench
===================================

SPI_WRITE_MASTER -- requirements
Module: spi_write_master

Interface
REQ-001 Parameter CLK_DIV, default 2: SCLK half-period in clk cycles; legal 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 spi_start  input  1  request; level-sensitive, sampled only when spi_ready=1.
REQ-005 spi_dir  input  1  0 = write only; 1 = write and capture miso.
REQ-006 spi_data_tx  input  24  frame data, right-aligned.
REQ-007 spi_data_depth  input  8  frame length in bits.
REQ-008 spi_ready  output  1  1 = idle and able to accept a request.
REQ-009 spi_data_rx  output  24  captured miso bits, right-aligned.
REQ-010 spi_rx_valid  output  1  one-cycle pulse when spi_data_rx updates.
REQ-011 spi_sclk  output  1  serial clock; mode 0, idle low.
REQ-012 spi_mosi  output  1  serial data out, MSB first.
REQ-013 spi_miso  input  1  serial data in; already synchronous to clk.
REQ-014 spi_cs_n  output  1  chip select / latch enable, active low; rising edge latches the frame (ADF4002 LE, LMX2594 CSB).

Function
REQ-015 Handshake: a request is accepted on a clk edge with spi_ready=1 and spi_start=1. The edge latches spi_data_tx, spi_dir and the effective depth D. spi_ready is 0 from the next cycle.
REQ-016 Effective depth: D = spi_data_depth for 1..24. D = 24 for 0 and for any value >24.
REQ-017 States and transitions:
  - IDLE -> SETUP on accept.
  - SETUP -> HIGH after CLK_DIV cycles.
  - HIGH -> LOW after CLK_DIV cycles.
  - LOW -> HIGH after CLK_DIV cycles if bits remain; otherwise LOW -> GAP.
  - GAP -> IDLE after CLK_DIV cycles.
REQ-018 SETUP: spi_cs_n=0, spi_sclk=0, spi_mosi = latched bit D-1.
REQ-019 HIGH: spi_sclk=1. spi_miso is sampled on the first HIGH cycle when dir=1.
REQ-020 LOW: spi_sclk=0. spi_mosi advances to the next lower bit on the first LOW cycle. The LOW phase after the last bit is the CS hold phase; spi_mosi is unchanged during it.
REQ-021 GAP: spi_cs_n=1, spi_sclk=0, spi_mosi=0, spi_ready=0.
REQ-022 Cycle timing, with the accept edge as cycle 0 and N=CLK_DIV:
  - spi_cs_n is low for cycles 1..N+2N·D.
  - spi_cs_n is high for cycles N+2N·D+1..2N+2N·D.
  - spi_ready=1 at cycle 2N+2N·D+1.
  - Exactly D sclk rising edges occur per frame.
REQ-023 Capture (dir=1): spi_data_rx = D sampled bits, first sample in bit D-1, all bits above D-1 zero. It is updated and spi_rx_valid pulses in the cycle spi_ready returns to 1.
REQ-024 dir=0 frames: spi_data_rx is not modified and spi_rx_valid stays 0.
REQ-025 spi_start while spi_ready=0 is ignored; requests are not queued. Input changes during a frame do not affect the frame.
REQ-026 Back-to-back: if spi_start is high in the cycle spi_ready returns to 1, the next frame is accepted on that edge. No extra idle cycle is required.
REQ-027 Internal counters are 8-bit (phase) and 5-bit (bit index). Bit counting ends at zero without wrap.

Reset
REQ-028 While rst=1, on every clk edge the outputs go to: spi_ready=1, spi_cs_n=1, spi_sclk=0, spi_mosi=0, spi_rx_valid=0, spi_data_rx=0, state=IDLE.
REQ-029 spi_start is ignored while rst=1.
REQ-030 rst asserted mid-frame aborts the frame. spi_cs_n rises on that edge with no latch-integrity guarantee, and no spi_rx_valid pulse is emitted.
REQ-031 The first accept is possible on the first edge with rst=0.

Verification
REQ-032 CLK_DIV=2, write 24'h1F8093, depth 24, start one cycle:
  - spi_cs_n low exactly 98 cycles.
  - 24 sclk rising edges; mosi sampled at those edges reads 1F8093 MSB first.
  - spi_ready high again at cycle 101.
REQ-033 Depth 0 and depth 40 each produce 24 sclk edges. Depth 8 with data 24'hABCDEF shifts out 8'hEF only.
REQ-034 dir=1, depth 16, miso driven with 16'hA5C3 MSB first:
  - spi_data_rx = 24'h00A5C3.
  - spi_rx_valid is a single pulse coincident with the spi_ready rise.
REQ-035 spi_start held high across four frames (ADF4002 init pattern) gives four frames with no idle cycle between GAP and the next SETUP. Data changes applied while busy are not sampled.
REQ-036 rst pulsed at the 10th sclk edge of a frame:
  - next cycle spi_cs_n=1, spi_sclk=0, spi_ready=1, no spi_rx_valid.
  - a new frame after reset completes normally.
REQ-037 CLK_DIV=1, depth 1: spi_cs_n low 3 cycles, high 1 cycle, spi_ready at cycle 5.

Source files
------------

// File: rtl/spi_write_master_if.sv
// Request/response and serial-pin bundle for spi_write_master.
// master: the SPI engine itself; slave: the requester and the attached device.
interface spi_write_master_if;
    logic        spi_start;
    logic        spi_dir;
    logic [23:0] spi_data_tx;
    logic [7:0]  spi_data_depth;
    logic        spi_ready;
    logic [23:0] spi_data_rx;
    logic        spi_rx_valid;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    modport master (
        input  spi_start,
        input  spi_dir,
        input  spi_data_tx,
        input  spi_data_depth,
        input  spi_miso,
        output spi_ready,
        output spi_data_rx,
        output spi_rx_valid,
        output spi_sclk,
        output spi_mosi,
        output spi_cs_n
    );

    modport slave (
        output spi_start,
        output spi_dir,
        output spi_data_tx,
        output spi_data_depth,
        output spi_miso,
        input  spi_ready,
        input  spi_data_rx,
        input  spi_rx_valid,
        input  spi_sclk,
        input  spi_mosi,
        input  spi_cs_n
    );
endinterface

// File: rtl/spi_write_master.sv
// Mode-0 SPI frame engine for PLL-style register writes (up to 24 bits, MSB first),
// with optional MISO capture; CS rising edge latches the frame in the device.
module spi_write_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    spi_write_master_if.master bus
);
    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StGap} state_e;

    state_e      state_q;
    logic [7:0]  phase_q;
    logic [4:0]  bit_q;
    logic        last_q;
    logic        dir_q;
    logic [23:0] tx_q;
    logic [23:0] rx_shift_q;
    logic [23:0] data_rx_q;
    logic        ready_q;
    logic        rx_valid_q;
    logic        sclk_q;
    logic        mosi_q;
    logic        cs_n_q;

    logic [4:0]  depth_eff;
    logic        phase_done;

    // Zero and oversize depths both mean a full 24-bit frame.
    always_comb begin
        depth_eff = 5'd24;
        if (bus.spi_data_depth != 8'd0 && bus.spi_data_depth <= 8'd24) begin
            depth_eff = bus.spi_data_depth[4:0];
        end
    end

    assign phase_done = (phase_q == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= 8'd0;
            bit_q      <= 5'd0;
            last_q     <= 1'b0;
            dir_q      <= 1'b0;
            tx_q       <= 24'd0;
            rx_shift_q <= 24'd0;
            data_rx_q  <= 24'd0;
            ready_q    <= 1'b1;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.spi_start) begin
                        state_q    <= StSetup;
                        phase_q    <= DivLast;
                        tx_q       <= bus.spi_data_tx;
                        dir_q      <= bus.spi_dir;
                        bit_q      <= depth_eff - 5'd1;
                        last_q     <= 1'b0;
                        rx_shift_q <= 24'd0;
                        mosi_q     <= bus.spi_data_tx[depth_eff - 5'd1];
                        cs_n_q     <= 1'b0;
                        ready_q    <= 1'b0;
                    end
                end

                StSetup: begin
                    if (phase_done) begin
                        state_q <= StHigh;
                        phase_q <= DivLast;
                        sclk_q  <= 1'b1;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end

                StHigh: begin
                    // MISO is captured once, at the end of the first high cycle.
                    if (dir_q && phase_q == DivLast) begin
                        rx_shift_q <= {rx_shift_q[22:0], bus.spi_miso};
                    end
                    if (phase_done) begin
                        state_q <= StLow;
                        phase_q <= DivLast;
                        sclk_q  <= 1'b0;
                        last_q  <= (bit_q == 5'd0);
                        if (bit_q != 5'd0) begin
                            bit_q  <= bit_q - 5'd1;
                            mosi_q <= tx_q[bit_q - 5'd1];
                        end
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end

                StLow: begin
                    if (phase_done) begin
                        phase_q <= DivLast;
                        if (last_q) begin
                            // Low phase after the final bit doubles as CS hold time.
                            state_q <= StGap;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            state_q <= StHigh;
                            sclk_q  <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end

                StGap: begin
                    if (phase_done) begin
                        state_q <= StIdle;
                        ready_q <= 1'b1;
                        if (dir_q) begin
                            data_rx_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spi_ready    = ready_q;
    assign bus.spi_data_rx  = data_rx_q;
    assign bus.spi_rx_valid = rx_valid_q;
    assign bus.spi_sclk     = sclk_q;
    assign bus.spi_mosi     = mosi_q;
    assign bus.spi_cs_n     = cs_n_q;
endmodule

// File: tb/tb_spi_write_master.sv
// Randomised bench for spi_write_master: frame timing, shifted data and MISO capture
// are predicted from the frame rules (depth, divider, pattern) and compared per frame.
module tb_spi_write_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        dir;
    logic        miso;
    logic        sel;
    logic [23:0] data_tx;
    logic [7:0]  depth;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_rx;

    spi_write_master_if bus2 ();
    spi_write_master_if bus1 ();

    assign bus2.spi_start      = start & ~sel;
    assign bus2.spi_dir        = dir;
    assign bus2.spi_data_tx    = data_tx;
    assign bus2.spi_data_depth = depth;
    assign bus2.spi_miso       = miso;
    assign bus1.spi_start      = start & sel;
    assign bus1.spi_dir        = dir;
    assign bus1.spi_data_tx    = data_tx;
    assign bus1.spi_data_depth = depth;
    assign bus1.spi_miso       = miso;

    spi_write_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    spi_write_master #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        m_ready, m_rx_valid, m_sclk, m_mosi, m_cs_n;
    logic [23:0] m_data_rx;
    assign m_ready    = sel ? bus1.spi_ready    : bus2.spi_ready;
    assign m_rx_valid = sel ? bus1.spi_rx_valid : bus2.spi_rx_valid;
    assign m_sclk     = sel ? bus1.spi_sclk     : bus2.spi_sclk;
    assign m_mosi     = sel ? bus1.spi_mosi     : bus2.spi_mosi;
    assign m_cs_n     = sel ? bus1.spi_cs_n     : bus2.spi_cs_n;
    assign m_data_rx  = sel ? bus1.spi_data_rx  : bus2.spi_data_rx;

    // Frame observations, relative to the accept edge (cycle 0).
    int          w_cs_low, w_cs_high, w_rises, w_ready_cyc, w_valids, w_valid_cyc;
    logic [23:0] w_mosi, w_rx;

    function automatic int eff_depth(input logic [7:0] dep);
        return (dep == 8'd0 || dep > 8'd24) ? 24 : int'(dep);
    endfunction

    function automatic logic [23:0] low_mask(input int d);
        logic [24:0] one;
        one = 25'd1;
        return 24'((one << d) - 25'd1);
    endfunction

    // Called in a cycle where the selected DUT is ready and inputs are set; plays the
    // device side on MISO and records the frame until ready returns.
    task automatic watch(input int d, input logic [23:0] pat, input bit hold, input bit poke);
        int   c;
        int   idx;
        logic prev;
        c = 0;
        idx = d - 1;
        prev = 1'b0;
        miso = pat[idx];
        w_cs_low = 0; w_cs_high = 0; w_rises = 0; w_valids = 0;
        w_ready_cyc = -1; w_valid_cyc = -1; w_mosi = 24'd0; w_rx = 24'd0;
        while (c < 2000) begin
            @(posedge clk); #1; c++;
            if (c == 1 && !hold) start = 1'b0;
            if (c == 3) begin
                data_tx = 24'($urandom);
                depth   = 8'($urandom);
                dir     = 1'($urandom);
                if (poke) start = 1'b1;
            end
            if (c == 4 && poke) start = 1'b0;
            if (m_cs_n === 1'b0) w_cs_low++;
            else if (m_ready !== 1'b1) w_cs_high++;
            if (m_sclk === 1'b1 && prev === 1'b0) begin
                w_rises++;
                w_mosi = {w_mosi[22:0], m_mosi};
            end
            if (m_sclk === 1'b0 && prev === 1'b1) begin
                idx--;
                miso = (idx >= 0) ? pat[idx] : 1'b0;
            end
            prev = m_sclk;
            if (m_rx_valid === 1'b1) begin
                w_valids++;
                w_valid_cyc = c;
                w_rx = m_data_rx;
            end
            if (m_ready === 1'b1) begin
                w_ready_cyc = c;
                return;
            end
        end
        total++; bad++;
        $display("FAIL watch_timeout: got %0d cycles without ready, required ready within 2000", c);
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; start = 1'b1; dir = 1'b0; miso = 1'b0;
        data_tx = 24'h1F8093; depth = 8'd24;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus2.spi_ready !== 1'b1 || bus1.spi_ready !== 1'b1) begin bad++;
            $display("FAIL rst_ready: got %b/%b required 1/1", bus2.spi_ready, bus1.spi_ready); end
        total++; if (bus2.spi_cs_n !== 1'b1 || bus2.spi_sclk !== 1'b0 || bus2.spi_mosi !== 1'b0) begin bad++;
            $display("FAIL rst_pins: got cs_n=%b sclk=%b mosi=%b required 1 0 0",
                     bus2.spi_cs_n, bus2.spi_sclk, bus2.spi_mosi); end
        total++; if (bus2.spi_rx_valid !== 1'b0 || bus2.spi_data_rx !== 24'd0) begin bad++;
            $display("FAIL rst_rx: got valid=%b rx=%h required 0 000000",
                     bus2.spi_rx_valid, bus2.spi_data_rx); end
        exp_rx = 24'd0;
        rst = 1'b0;
        // First edge with reset low must accept the pending request.
        watch(24, 24'd0, 1'b0, 1'b0);
        total++; if (w_cs_low !== 98) begin bad++;
            $display("FAIL first_cs_low: got %0d required 98", w_cs_low); end
        total++; if (w_rises !== 24) begin bad++;
            $display("FAIL first_rises: got %0d required 24", w_rises); end
        total++; if (w_mosi !== 24'h1F8093) begin bad++;
            $display("FAIL first_mosi: got %h required 1f8093", w_mosi); end
        total++; if (w_ready_cyc !== 101) begin bad++;
            $display("FAIL first_ready_cycle: got %0d required 101", w_ready_cyc); end
        total++; if (w_cs_high !== 2 || w_valids !== 0) begin bad++;
            $display("FAIL first_gap_valid: got gap=%0d valids=%0d required 2 0", w_cs_high, w_valids); end
    endtask

    task automatic test_depth_edge();
        logic [7:0]  deps [3];
        logic [23:0] dats [3];
        deps = '{8'd0, 8'd40, 8'd8};
        dats = '{24'($urandom), 24'($urandom), 24'hABCDEF};
        for (int i = 0; i < 3; i++) begin
            int d;
            d = eff_depth(deps[i]);
            data_tx = dats[i]; depth = deps[i]; dir = 1'b0; start = 1'b1;
            watch(d, 24'd0, 1'b0, 1'b0);
            total++; if (w_rises !== d) begin bad++;
                $display("FAIL depth%0d_rises: got %0d required %0d", deps[i], w_rises, d); end
            total++; if (w_mosi !== (dats[i] & low_mask(d))) begin bad++;
                $display("FAIL depth%0d_mosi: got %h required %h", deps[i], w_mosi,
                         dats[i] & low_mask(d)); end
        end
    endtask

    task automatic test_capture();
        data_tx = 24'($urandom); depth = 8'd16; dir = 1'b1; start = 1'b1;
        watch(16, 24'h5AA5C3, 1'b0, 1'b0);
        exp_rx = 24'h00A5C3;
        total++; if (w_rx !== 24'h00A5C3) begin bad++;
            $display("FAIL capture_rx: got %h required 00a5c3", w_rx); end
        total++; if (w_valids !== 1 || w_valid_cyc !== w_ready_cyc) begin bad++;
            $display("FAIL capture_pulse: got %0d pulses at %0d required 1 at %0d",
                     w_valids, w_valid_cyc, w_ready_cyc); end
        @(posedge clk); #1;
        total++; if (m_rx_valid !== 1'b0 || m_data_rx !== 24'h00A5C3) begin bad++;
            $display("FAIL capture_hold: got valid=%b rx=%h required 0 00a5c3", m_rx_valid, m_data_rx); end
        data_tx = 24'($urandom); depth = 8'd12; dir = 1'b0; start = 1'b1;
        watch(12, 24'hFFFFFF, 1'b0, 1'b0);
        total++; if (w_valids !== 0 || m_data_rx !== 24'h00A5C3) begin bad++;
            $display("FAIL write_only_rx: got valids=%0d rx=%h required 0 00a5c3", w_valids, m_data_rx); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [23:0] dt, pat;
            logic [7:0]  dp;
            logic        dr;
            bit          pk;
            int          d;
            dt = 24'($urandom); pat = 24'($urandom); dp = 8'($urandom_range(0, 30));
            dr = 1'($urandom); pk = (i % 2) == 1;
            d = eff_depth(dp);
            data_tx = dt; depth = dp; dir = dr; start = 1'b1;
            watch(d, pat, 1'b0, pk);
            if (dr) exp_rx = pat & low_mask(d);
            total++; if (w_mosi !== (dt & low_mask(d)) || w_rises !== d) begin bad++;
                $display("FAIL rand%0d_mosi: got %h/%0d required %h/%0d", i, w_mosi, w_rises,
                         dt & low_mask(d), d); end
            total++; if (w_cs_low !== 2 + 4 * d || w_cs_high !== 2 || w_ready_cyc !== 5 + 4 * d) begin
                bad++;
                $display("FAIL rand%0d_timing: got low=%0d high=%0d ready=%0d required %0d 2 %0d",
                         i, w_cs_low, w_cs_high, w_ready_cyc, 2 + 4 * d, 5 + 4 * d); end
            total++; if (w_valids !== (dr ? 1 : 0) || m_data_rx !== exp_rx) begin bad++;
                $display("FAIL rand%0d_rx: got valids=%0d rx=%h required %0d %h", i, w_valids,
                         m_data_rx, dr ? 1 : 0, exp_rx); end
            if (pk) begin
                @(posedge clk); #1;
                total++; if (m_ready !== 1'b1 || m_cs_n !== 1'b1) begin bad++;
                    $display("FAIL rand%0d_no_queue: got ready=%b cs_n=%b required 1 1",
                             i, m_ready, m_cs_n); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] words [4];
        words = '{24'h1F8093, 24'h1F8092, 24'h000014, 24'h0F8001};
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_tx = words[i]; depth = 8'd24; dir = 1'b0;
            watch(24, 24'd0, i < 3, 1'b0);
            total++; if (w_mosi !== words[i]) begin bad++;
                $display("FAIL b2b%0d_mosi: got %h required %h", i, w_mosi, words[i]); end
            total++; if (w_ready_cyc !== 101 || w_cs_high !== 2 || w_cs_low !== 98) begin bad++;
                $display("FAIL b2b%0d_timing: got ready=%0d high=%0d low=%0d required 101 2 98",
                         i, w_ready_cyc, w_cs_high, w_cs_low); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int r;
        logic prev;
        logic [23:0] dt;
        c = 0; r = 0; prev = 1'b0;
        data_tx = 24'($urandom); depth = 8'd24; dir = 1'b1; start = 1'b1; miso = 1'b1;
        while (r < 10 && c < 500) begin
            @(posedge clk); #1; c++;
            if (c == 1) start = 1'b0;
            if (m_sclk === 1'b1 && prev === 1'b0) r++;
            prev = m_sclk;
        end
        total++; if (r !== 10) begin bad++;
            $display("FAIL midrst_reach: got %0d edges required 10", r); end
        rst = 1'b1;
        @(posedge clk); #1;
        exp_rx = 24'd0;
        total++; if (m_cs_n !== 1'b1 || m_sclk !== 1'b0 || m_ready !== 1'b1) begin bad++;
            $display("FAIL midrst_pins: got cs_n=%b sclk=%b ready=%b required 1 0 1",
                     m_cs_n, m_sclk, m_ready); end
        total++; if (m_rx_valid !== 1'b0 || m_data_rx !== 24'd0) begin bad++;
            $display("FAIL midrst_rx: got valid=%b rx=%h required 0 000000", m_rx_valid, m_data_rx); end
        rst = 1'b0;
        dt = 24'($urandom);
        data_tx = dt; depth = 8'd20; dir = 1'b0; start = 1'b1;
        watch(20, 24'd0, 1'b0, 1'b0);
        total++; if (w_mosi !== (dt & low_mask(20)) || w_ready_cyc !== 85) begin bad++;
            $display("FAIL midrst_after: got %h ready=%0d required %h 85", w_mosi, w_ready_cyc,
                     dt & low_mask(20)); end
    endtask

    task automatic test_div1();
        sel = 1'b1;
        data_tx = 24'h000001; depth = 8'd1; dir = 1'b1; start = 1'b1;
        watch(1, 24'h000001, 1'b0, 1'b0);
        total++; if (w_cs_low !== 3 || w_cs_high !== 1 || w_ready_cyc !== 5) begin bad++;
            $display("FAIL div1_timing: got low=%0d high=%0d ready=%0d required 3 1 5",
                     w_cs_low, w_cs_high, w_ready_cyc); end
        total++; if (w_rises !== 1 || w_mosi !== 24'h000001 || w_rx !== 24'h000001) begin bad++;
            $display("FAIL div1_data: got rises=%0d mosi=%h rx=%h required 1 000001 000001",
                     w_rises, w_mosi, w_rx); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_depth_edge();
        test_capture();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
